// File: rtl/fifo_drain_pkg.sv
// Shared types and default sizing for the FIFO read-side drain controller.
package fifo_drain_pkg;

  localparam int unsigned WIDTH_DEF     = 8;
  localparam int unsigned DEPTH_DEF     = 256;
  localparam int unsigned BURST_LEN_DEF = 16;
  localparam int unsigned TIMEOUT_DEF   = 64;

  localparam int unsigned CNT_W = $clog2(BURST_LEN_DEF + 1);
  localparam int unsigned TMR_W = $clog2(TIMEOUT_DEF + 1);

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_BURST      = 2'd1,
    ST_FLUSH      = 2'd2,
    ST_WAIT_EMPTY = 2'd3
  } drain_state_e;

endpackage

// File: rtl/skid_buf2.sv
// Two-entry output buffer carrying {last, data}; the head entry drives the stream registers.
module skid_buf2 #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         push_last,
  output logic [W-1:0] m_data,
  output logic         m_last,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [1:0]   occ
);

  logic [W:0] head_q;
  logic [W:0] tail_q;
  logic [1:0] occ_q;
  logic       pop_c;

  assign pop_c   = m_valid && m_ready;
  assign m_data  = head_q[W-1:0];
  assign m_last  = head_q[W];
  assign m_valid = (occ_q != 2'd0);
  assign occ     = occ_q;

  // Head/tail shuffle on push and pop; the head only changes when it is consumed or refilled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= 2'd0;
    end else begin
      case ({push, pop_c})
        2'b10: begin
          if (occ_q == 2'd0) begin
            head_q <= {push_last, push_data};
            occ_q  <= 2'd1;
          end else if (occ_q == 2'd1) begin
            tail_q <= {push_last, push_data};
            occ_q  <= 2'd2;
          end
        end
        2'b01: begin
          if (occ_q == 2'd2) head_q <= tail_q;
          occ_q <= occ_q - 2'd1;
        end
        2'b11: begin
          if (occ_q == 2'd1) begin
            head_q <= {push_last, push_data};
          end else begin
            head_q <= tail_q;
            tail_q <= {push_last, push_data};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_drain_ctrl.sv
// Read-side drain controller: pulls FIFO words in bursts or timeout flushes onto a valid/ready stream.
module fifo_drain_ctrl
  import fifo_drain_pkg::*;
#(
  parameter int unsigned WIDTH     = WIDTH_DEF,
  parameter int unsigned DEPTH     = DEPTH_DEF,
  parameter int unsigned BURST_LEN = BURST_LEN_DEF,
  parameter int unsigned TIMEOUT   = TIMEOUT_DEF
) (
  input  logic             rclk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             fifo_empty,
  input  logic             fifo_half_full,
  input  logic [WIDTH-1:0] fifo_rdata,
  output logic             fifo_r_en,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last,
  output logic [15:0]      words_drained
);

  localparam int unsigned CW = $clog2(BURST_LEN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  // A burst must fit in the half of the FIFO that raised the flag.
  if (BURST_LEN > DEPTH / 2) begin : g_bad_cfg
    $error("fifo_drain_ctrl: BURST_LEN must not exceed DEPTH/2");
  end

  drain_state_e  state, state_nxt;
  logic [CW-1:0] rd_cnt, rd_cnt_nxt;
  logic [TW-1:0] idle_tmr, idle_tmr_nxt;
  logic          inflight;
  logic          inflight_last;
  logic [1:0]    occ;
  logic          pop_c;
  logic          issuing_c;
  logic          rd_last_c;
  logic [2:0]    fill_c;

  assign pop_c     = m_valid && m_ready;
  assign issuing_c = (state == ST_BURST) || (state == ST_FLUSH);
  assign rd_last_c = (state == ST_FLUSH) || (rd_cnt == CW'(BURST_LEN - 1));
  // Buffer slots already claimed after this cycle's pop: stored words plus the read in flight.
  assign fill_c    = 3'(occ) + 3'(inflight) - 3'(pop_c);
  assign fifo_r_en = issuing_c && !fifo_empty && (fill_c < 3'd2);

  // State, counters and in-flight read tag.
  always_ff @(posedge rclk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      rd_cnt        <= '0;
      idle_tmr      <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      words_drained <= 16'd0;
    end else begin
      state         <= state_nxt;
      rd_cnt        <= rd_cnt_nxt;
      idle_tmr      <= idle_tmr_nxt;
      inflight      <= fifo_r_en;
      inflight_last <= fifo_r_en && rd_last_c;
      if (pop_c) words_drained <= words_drained + 16'd1;
    end
  end

  // Next-state, burst counter and idle timer.
  always_comb begin
    state_nxt  = state;
    rd_cnt_nxt = rd_cnt;
    if (fifo_empty) begin
      idle_tmr_nxt = '0;
    end else if (!fifo_half_full && (idle_tmr != TW'(TIMEOUT))) begin
      idle_tmr_nxt = idle_tmr + TW'(1);
    end else begin
      idle_tmr_nxt = idle_tmr;
    end

    case (state)
      ST_IDLE: begin
        if (enable && fifo_half_full) begin
          state_nxt    = ST_BURST;
          rd_cnt_nxt   = '0;
          idle_tmr_nxt = '0;
        end else if (enable && (idle_tmr == TW'(TIMEOUT))) begin
          state_nxt = ST_FLUSH;
        end
      end
      ST_BURST: begin
        if (fifo_r_en) begin
          rd_cnt_nxt = rd_cnt + CW'(1);
          if (rd_last_c) state_nxt = ST_WAIT_EMPTY;
        end
      end
      ST_FLUSH: begin
        if (fifo_r_en) state_nxt = ST_WAIT_EMPTY;
      end
      ST_WAIT_EMPTY: begin
        if ((occ == 2'd0) && !inflight) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  skid_buf2 #(
    .W (WIDTH)
  ) u_buf (
    .clk       (rclk),
    .rst_n     (reset_n),
    .push      (inflight),
    .push_data (fifo_rdata),
    .push_last (inflight_last),
    .m_data    (m_data),
    .m_last    (m_last),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .occ       (occ)
  );

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Directed bench for fifo_drain_ctrl with a behavioural FIFO and a stream scoreboard.
module tb_fifo_drain_ctrl;

  logic        rclk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        fifo_empty;
  logic        fifo_half_full;
  logic [7:0]  fifo_rdata;
  logic        fifo_r_en;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;
  logic [15:0] words_drained;

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0] fifo_q[$];
  logic [8:0] exp_q[$];
  int  wr_total  = 0;
  int  rd_total  = 0;
  int  rd_issued = 0;
  int  pop_total = 0;
  int  hf_level  = 16;
  logic force_empty = 1'b0;

  logic       stall_q = 1'b0;
  logic [8:0] hold_q  = '0;
  logic [8:0] exp_w;
  logic       pop_now;

  always #5 rclk = ~rclk;

  // The half-full flag comes from a programmable level so small word counts can trigger bursts.
  assign fifo_empty     = force_empty || (wr_total == rd_total);
  assign fifo_half_full = ((wr_total - rd_total) >= hf_level);

  fifo_drain_ctrl dut (
    .rclk           (rclk),
    .reset_n        (reset_n),
    .enable         (enable),
    .fifo_empty     (fifo_empty),
    .fifo_half_full (fifo_half_full),
    .fifo_rdata     (fifo_rdata),
    .fifo_r_en      (fifo_r_en),
    .m_data         (m_data),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .m_last         (m_last),
    .words_drained  (words_drained)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // FIFO read port: data appears the cycle after r_en; counters track reads and pops.
  always @(posedge rclk or negedge reset_n) begin
    if (!reset_n) begin
      fifo_q.delete();
      rd_total   <= wr_total;
      rd_issued  <= 0;
      pop_total  <= 0;
      fifo_rdata <= 8'h00;
    end else begin
      if (fifo_r_en) begin
        if (fifo_q.size() != 0) fifo_rdata <= fifo_q.pop_front();
        rd_total  <= rd_total + 1;
        rd_issued <= rd_issued + 1;
      end
      if (m_valid && m_ready) pop_total <= pop_total + 1;
    end
  end

  // Stream scoreboard, hold-while-stalled and read-gating checks, sampled mid-cycle.
  always begin
    @(negedge rclk);
    #1;
    if (!reset_n) begin
      stall_q = 1'b0;
    end else begin
      pop_now = m_valid && m_ready;
      if (stall_q)
        chk("hold_stable", 32'({m_valid, m_last, m_data}), 32'({1'b1, hold_q}));
      if (pop_now) begin
        chk("word_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          exp_w = exp_q.pop_front();
          chk("m_data", 32'(m_data), 32'(exp_w[7:0]));
          chk("m_last", 32'(m_last), 32'(exp_w[8]));
        end
      end
      if (fifo_r_en) begin
        chk("rd_when_empty", 32'(fifo_empty), 32'd0);
        chk("rd_bound", 32'((rd_issued - pop_total - int'(pop_now)) < 2), 32'd1);
      end
      stall_q = m_valid && !m_ready;
      hold_q  = {m_last, m_data};
    end
  end

  task automatic write_words(input int base, input int n, input bit flush_tags);
    for (int i = 0; i < n; i++) begin
      fifo_q.push_back(8'(base + i));
      exp_q.push_back({flush_tags || ((i % 16) == 15), 8'(base + i)});
      wr_total++;
    end
  endtask

  task automatic wait_pops(input int target, input int budget, input bit toggle);
    int n = 0;
    while ((pop_total < target) && (n < budget)) begin
      @(negedge rclk);
      if (toggle) m_ready = ~m_ready;
      n++;
    end
    m_ready = 1'b1;
    chk("drain_count", 32'(pop_total), 32'(target));
  endtask

  task automatic end_test();
    repeat (4) @(negedge rclk);
    chk("fifo_left", 32'(wr_total - rd_total), 32'd0);
    chk("exp_left", 32'(exp_q.size()), 32'd0);
    chk("words_drained", 32'(words_drained), 32'(16'(pop_total)));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int r0;
    reset_n = 1'b0;
    enable  = 1'b0;
    m_ready = 1'b1;
    repeat (3) @(negedge rclk);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_last", 32'(m_last), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
    chk("rst_words", 32'(words_drained), 32'd0);
    chk("rst_r_en", 32'(fifo_r_en), 32'd0);
    reset_n = 1'b1;

    // Eight back-to-back bursts of 16, last on every 16th word.
    @(negedge rclk);
    write_words(0, 128, 1'b0);
    enable = 1'b1;
    wait_pops(128, 600, 1'b0);
    end_test();
    chk("drained_128", 32'(words_drained), 32'd128);

    // Trickle: three words, no half-full, flushed singly after the idle timeout.
    hf_level = 1000;
    @(negedge rclk);
    base = pop_total;
    write_words(0, 3, 1'b1);
    repeat (60) @(negedge rclk);
    chk("no_early_flush", 32'(pop_total), 32'(base));
    wait_pops(base + 3, 100, 1'b0);
    end_test();

    // Burst under a toggling sink.
    hf_level = 16;
    @(negedge rclk);
    base = pop_total;
    write_words(16, 16, 1'b0);
    wait_pops(base + 16, 200, 1'b1);
    end_test();

    // FIFO reports empty for five cycles mid-burst.
    @(negedge rclk);
    base = pop_total;
    write_words(32, 16, 1'b0);
    wait_pops(base + 5, 50, 1'b0);
    force_empty = 1'b1;
    r0 = rd_issued;
    repeat (5) @(negedge rclk);
    chk("stall_no_reads", 32'(rd_issued), 32'(r0));
    force_empty = 1'b0;
    wait_pops(base + 16, 100, 1'b0);
    end_test();

    // Enable dropped mid-burst: the burst finishes, the next one waits for enable.
    @(negedge rclk);
    base = pop_total;
    write_words(64, 32, 1'b0);
    wait_pops(base + 5, 50, 1'b0);
    enable = 1'b0;
    wait_pops(base + 16, 60, 1'b0);
    repeat (60) @(negedge rclk);
    chk("no_burst_disabled", 32'(pop_total), 32'(base + 16));
    chk("hf_still_set", 32'(fifo_half_full), 32'd1);
    enable = 1'b1;
    wait_pops(base + 32, 100, 1'b0);
    end_test();

    // Asynchronous reset mid-burst.
    @(negedge rclk);
    base = pop_total;
    write_words(100, 16, 1'b0);
    wait_pops(base + 4, 50, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_m_valid", 32'(m_valid), 32'd0);
    chk("arst_r_en", 32'(fifo_r_en), 32'd0);
    chk("arst_words", 32'(words_drained), 32'd0);
    exp_q.delete();
    enable = 1'b0;
    @(negedge rclk);
    reset_n = 1'b1;
    repeat (5) @(negedge rclk);
    chk("post_rst_idle", 32'({m_valid, fifo_r_en}), 32'd0);
    enable = 1'b1;
    write_words(200, 16, 1'b0);
    wait_pops(16, 100, 1'b0);
    end_test();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
